// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-enable divider, x/y counters and registered sync/active/strobe outputs.
// Optional colour-bar test pattern on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int PIX_DIV  = 1,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [11:0]   rgb
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    // One extra bit so window ends equal to 2**CW still compare correctly
    localparam logic [CW:0]   HS_START = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   VS_START = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW:0]   HA_LIM   = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   VA_LIM   = (CW+1)'(V_ACTIVE);
    localparam logic          HP       = (H_POL != 0);
    localparam logic          VP       = (V_POL != 0);

    logic [DW-1:0] div_cnt_reg, div_cnt_next;
    logic [CW-1:0] x_reg, x_next;
    logic [CW-1:0] y_reg, y_next;
    logic          hsync_reg, hsync_next;
    logic          vsync_reg, vsync_next;
    logic          active_reg, active_next;
    logic          line_start_reg;
    logic          frame_start_reg;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;

    always_comb begin
        tick   = en & ~rst & (div_cnt_reg == DIV_LAST);
        h_wrap = (x_reg == H_LAST);
        v_wrap = (y_reg == V_LAST);

        div_cnt_next = div_cnt_reg;
        if (en) begin
            div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
        end

        x_next = x_reg;
        y_next = y_reg;
        if (tick) begin
            x_next = h_wrap ? '0 : x_reg + 1'b1;
            if (h_wrap) begin
                y_next = v_wrap ? '0 : y_reg + 1'b1;
            end
        end

        // Decoded from the next coordinates so the registered flags line up with x/y
        hsync_next  = (({1'b0, x_next} >= HS_START) && ({1'b0, x_next} < HS_END)) ? HP : ~HP;
        vsync_next  = (({1'b0, y_next} >= VS_START) && ({1'b0, y_next} < VS_END)) ? VP : ~VP;
        active_next = ({1'b0, x_next} < HA_LIM) && ({1'b0, y_next} < VA_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg     <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            hsync_reg       <= ~HP;
            vsync_reg       <= ~VP;
            active_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            div_cnt_reg     <= div_cnt_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            line_start_reg  <= tick & h_wrap;
            frame_start_reg <= tick & h_wrap & v_wrap;
            // Flags only move on pixel edges, so the reset pixel stays blanked until the first tick
            if (tick) begin
                hsync_reg  <= hsync_next;
                vsync_reg  <= vsync_next;
                active_reg <= active_next;
            end
        end
    end

    assign pix_tick    = tick;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign active      = active_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign line_start  = line_start_reg & en & ~rst;
    assign frame_start = frame_start_reg & en & ~rst;

`ifdef VGA_TEST_PATTERN_EN
    logic [6:0]  bar_ge;
    logic [2:0]  bar_next;
    logic [11:0] rgb_next;
    logic [11:0] rgb_reg;

    // Bar index = x*8/H_ACTIVE, found by comparing against the seven bar boundaries
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
        localparam logic [CW:0] EDGE = (CW+1)'((gi * H_ACTIVE + 7) / 8);
        assign bar_ge[gi-1] = ({1'b0, x_next} >= EDGE);
    end

    always_comb begin
        bar_next = '0;
        for (int i = 0; i < 7; i++) begin
            bar_next = bar_next + {2'b00, bar_ge[i]};
        end
        rgb_next = active_next ? {{4{bar_next[0]}}, {4{bar_next[1]}}, {4{bar_next[2]}}} : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_reg <= '0;
        end else if (tick) begin
            rgb_reg <= rgb_next;
        end
    end

    assign rgb = rgb_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed table, hand-written corner sequences and a randomized
// run of two small-mode instances against an arithmetic pixel-count model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small mode S: HT=17 (hsync x 12..14, low), VT=12 (vsync y 7..8, low), PIX_DIV=1
    localparam int S_HA = 10, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 3;
    // Small mode D: HT=15, VT=8, positive syncs, PIX_DIV=3
    localparam int D_HA = 8,  D_HF = 2, D_HS = 2, D_HB = 3;
    localparam int D_VA = 4,  D_VF = 1, D_VS = 1, D_VB = 2;

    logic        rst_a, en_a, pt_a, hs_a, vs_a, act_a, ls_a, fs_a;
    logic [11:0] x_a, y_a;
    logic        rst_s, en_s, pt_s, hs_s, vs_s, act_s, ls_s, fs_s;
    logic [5:0]  x_s, y_s;
    logic        rst_d, en_d, pt_d, hs_d, vs_d, act_d, ls_d, fs_d;
    logic [5:0]  x_d, y_d;
    logic [11:0] rgb_a, rgb_s, rgb_d;

`ifndef VGA_TEST_PATTERN_EN
    assign rgb_a = 12'h000;
    assign rgb_s = 12'h000;
    assign rgb_d = 12'h000;
`endif

    vga_timing_gen u_def (
        .clk(clk), .rst(rst_a), .en(en_a), .pix_tick(pt_a), .hsync(hs_a), .vsync(vs_a),
        .active(act_a), .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb(rgb_a)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .H_POL(0), .V_POL(0), .PIX_DIV(1), .CW(6)
    ) u_sm (
        .clk(clk), .rst(rst_s), .en(en_s), .pix_tick(pt_s), .hsync(hs_s), .vsync(vs_s),
        .active(act_s), .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb(rgb_s)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(D_HA), .H_FP(D_HF), .H_SYNC(D_HS), .H_BP(D_HB),
        .V_ACTIVE(D_VA), .V_FP(D_VF), .V_SYNC(D_VS), .V_BP(D_VB),
        .H_POL(1), .V_POL(1), .PIX_DIV(3), .CW(6)
    ) u_dv (
        .clk(clk), .rst(rst_d), .en(en_d), .pix_tick(pt_d), .hsync(hs_d), .vsync(vs_d),
        .active(act_d), .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb(rgb_d)
`endif
    );

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, div;
    } mode_t;

    typedef struct {
        int x, y, hs, vs, act, pt, ls, fs, rgb;
    } exp_t;

    typedef struct {
        bit r, e;
        int ncyc, x, y, act, hs, ls;
    } vec_t;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outputs follow from the count of enabled clocks since reset: ticks = n/div, pixel = ticks mod frame
    function automatic exp_t model(input mode_t m, input int n, input int lt, input int r, input int e);
        exp_t o;
        int   t, ht, vt, bar;
        ht    = m.ha + m.hf + m.hs + m.hb;
        vt    = m.va + m.vf + m.vs + m.vb;
        t     = n / m.div;
        o.x   = t % ht;
        o.y   = (t / ht) % vt;
        o.act = (t > 0 && o.x < m.ha && o.y < m.va) ? 1 : 0;
        o.hs  = (o.x >= m.ha + m.hf && o.x < m.ha + m.hf + m.hs) ? m.hp : 1 - m.hp;
        o.vs  = (o.y >= m.va + m.vf && o.y < m.va + m.vf + m.vs) ? m.vp : 1 - m.vp;
        o.pt  = (e != 0 && r == 0 && (n % m.div) == m.div - 1) ? 1 : 0;
        o.ls  = (e != 0 && r == 0 && lt != 0 && o.x == 0) ? 1 : 0;
        o.fs  = (o.ls != 0 && o.y == 0) ? 1 : 0;
        bar   = o.x * 8 / m.ha;
        o.rgb = 0;
        if (o.act != 0) begin
            if ((bar & 1) != 0) o.rgb = o.rgb + 'hF00;
            if ((bar & 2) != 0) o.rgb = o.rgb + 'h0F0;
            if ((bar & 4) != 0) o.rgb = o.rgb + 'h00F;
        end
        return o;
    endfunction

    task automatic cmp_dut(input string tag, input mode_t m, input int n, input int lt, input int r,
                           input int e, input int ax, input int ay, input int ahs, input int avs,
                           input int aact, input int apt, input int als, input int afs, input int argb);
        exp_t o;
        o = model(m, n, lt, r, e);
        chk({tag, " x"}, ax, o.x);
        chk({tag, " y"}, ay, o.y);
        chk({tag, " hsync"}, ahs, o.hs);
        chk({tag, " vsync"}, avs, o.vs);
        chk({tag, " active"}, aact, o.act);
        chk({tag, " pix_tick"}, apt, o.pt);
        chk({tag, " line_start"}, als, o.ls);
        chk({tag, " frame_start"}, afs, o.fs);
`ifdef VGA_TEST_PATTERN_EN
        chk({tag, " rgb"}, argb, o.rgb);
`else
        if (argb != 0) chk({tag, " rgb"}, argb, 0);
`endif
    endtask

    initial begin
        vec_t  vt[$];
        mode_t m_s, m_d;
        int    n_s, lt_s, n_d, lt_d;
        bit    found;
        int    hx, hy, hhs, hvs;

        rst_a = 1'b1; en_a = 1'b0;
        rst_s = 1'b1; en_s = 1'b0;
        rst_d = 1'b1; en_d = 1'b0;
        m_s = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 0, 0, 1};
        m_d = '{D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, 1, 1, 3};

        // ---------------- directed table on the small mode ----------------
        //          r  e  ncyc  x  y act hs ls
        vt.push_back('{1, 1, 1,  0, 0, 0, 1, 0});
        vt.push_back('{0, 1, 1,  1, 0, 1, 1, 0});
        vt.push_back('{0, 0, 3,  1, 0, 1, 1, 0});
        vt.push_back('{0, 1, 9, 10, 0, 0, 1, 0});
        vt.push_back('{0, 1, 2, 12, 0, 0, 0, 0});
        vt.push_back('{0, 1, 2, 14, 0, 0, 0, 0});
        vt.push_back('{0, 1, 1, 15, 0, 0, 1, 0});
        vt.push_back('{0, 1, 1, 16, 0, 0, 1, 0});
        vt.push_back('{0, 1, 1,  0, 1, 1, 1, 1});
        vt.push_back('{0, 0, 1,  0, 1, 1, 1, 0});
        vt.push_back('{1, 1, 1,  0, 0, 0, 1, 0});
        for (int i = 0; i < vt.size(); i++) begin
            for (int k = 0; k < vt[i].ncyc; k++) begin
                @(negedge clk);
                rst_s = vt[i].r;
                en_s  = vt[i].e;
                @(posedge clk);
                #1;
            end
            chk($sformatf("tbl%0d x", i), int'(x_s), vt[i].x);
            chk($sformatf("tbl%0d y", i), int'(y_s), vt[i].y);
            chk($sformatf("tbl%0d active", i), int'(act_s), vt[i].act);
            chk($sformatf("tbl%0d hsync", i), int'(hs_s), vt[i].hs);
            chk($sformatf("tbl%0d line_start", i), int'(ls_s), vt[i].ls);
        end

        // ---------------- freeze at last active pixel ----------------
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            rst_s = 1'b0;
            en_s  = 1'b1;
            @(posedge clk);
            #1;
            if (x_s == 6'd9 && y_s == 6'd5) found = 1'b1;
        end
        chk("freeze reach x=9,y=5", int'(found), 1);
        hx = int'(x_s); hy = int'(y_s); hhs = int'(hs_s); hvs = int'(vs_s);
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            en_s = 1'b0;
            #1;
            chk("freeze pix_tick", int'(pt_s), 0);
            @(posedge clk);
            #1;
            chk("freeze x", int'(x_s), hx);
            chk("freeze y", int'(y_s), hy);
            chk("freeze hsync", int'(hs_s), hhs);
            chk("freeze vsync", int'(vs_s), hvs);
            chk("freeze line_start", int'(ls_s), 0);
        end
        @(negedge clk);
        en_s = 1'b1;
        @(posedge clk);
        #1;
        chk("resume x", int'(x_s), 10);
        chk("resume y", int'(y_s), 5);
        chk("resume active", int'(act_s), 0);

        // ---------------- reset pulse mid-frame inside both sync pulses ----------------
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            en_s = 1'b1;
            @(posedge clk);
            #1;
            if (x_s == 6'd13 && y_s == 6'd7) found = 1'b1;
        end
        chk("midrst reach x=13,y=7", int'(found), 1);
        chk("midrst hsync active", int'(hs_s), 0);
        chk("midrst vsync active", int'(vs_s), 0);
        @(negedge clk);
        rst_s = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst x", int'(x_s), 0);
        chk("midrst y", int'(y_s), 0);
        chk("midrst hsync", int'(hs_s), 1);
        chk("midrst vsync", int'(vs_s), 1);
        chk("midrst active", int'(act_s), 0);
        chk("midrst pix_tick", int'(pt_s), 0);
        chk("midrst line_start", int'(ls_s), 0);
        chk("midrst frame_start", int'(fs_s), 0);
        @(negedge clk);
        rst_s = 1'b0;

        // ---------------- default 640x480 line: hsync window and period ----------------
        begin
            int f0, f1, r0, fx, rx, nls;
            logic prev;
            f0 = -1; f1 = -1; r0 = -1; fx = -1; rx = -1; nls = 0;
            @(negedge clk);
            rst_a = 1'b1; en_a = 1'b1;
            @(posedge clk);
            #1;
            prev = hs_a;
            @(negedge clk);
            rst_a = 1'b0;
            for (int c = 1; c <= 2000 && f1 < 0; c++) begin
                @(posedge clk);
                #1;
                if (ls_a) nls++;
                if (prev && !hs_a) begin
                    if (f0 < 0) begin f0 = c; fx = int'(x_a); end
                    else f1 = c;
                end
                if (!prev && hs_a && r0 < 0) begin r0 = c; rx = int'(x_a); end
                prev = hs_a;
`ifdef VGA_TEST_PATTERN_EN
                if (c == 1)   chk("pattern x=1 bar0", int'(rgb_a), 'h000);
                if (c == 80)  chk("pattern x=80 bar1", int'(rgb_a), 'hF00);
                if (c == 400) chk("pattern x=400 bar5", int'(rgb_a), 'hF0F);
                if (c == 560) chk("pattern x=560 bar7", int'(rgb_a), 'hFFF);
                if (c == 700) chk("pattern blank", int'(rgb_a), 'h000);
`endif
            end
            chk("hsync fall x", fx, 656);
            chk("hsync rise x", rx, 752);
            chk("hsync low clks", r0 - f0, 96);
            chk("hsync period", f1 - f0, 800);
            chk("default line_start count", nls, 1);
            chk("default pix_tick", int'(pt_a), 1);
            chk("default vsync", int'(vs_a), 1);
            chk("default frame_start", int'(fs_a), 0);
        end

        // ---------------- divider: PIX_DIV=3 ----------------
        begin
            int nt, ft, l0, l1, nchg;
            logic [5:0] px;
            nt = 0; ft = -1; l0 = -1; l1 = -1; nchg = 0;
            @(negedge clk);
            rst_d = 1'b1; en_d = 1'b1;
            @(posedge clk);
            #1;
            px = x_d;
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                rst_d = 1'b0;
                en_d  = 1'b1;
                #1;
                if (pt_d) begin
                    nt++;
                    if (ft < 0) ft = c;
                end
                @(posedge clk);
                #1;
                if (x_d != px) nchg++;
                px = x_d;
                if (ls_d) begin
                    if (l0 < 0) l0 = c;
                    else if (l1 < 0) l1 = c;
                end
            end
            chk("div first tick", ft, 2);
            chk("div tick count", nt, 40);
            chk("div x changes", nchg, 40);
            chk("div first line_start", l0, 44);
            chk("div line period", l1 - l0, 45);
        end

        // ---------------- randomized run of both small modes vs model ----------------
        n_s = 0; lt_s = 0; n_d = 0; lt_d = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_s = (i == 0) || ($urandom_range(0, 399) == 0);
            en_s  = ($urandom_range(0, 9) != 0);
            rst_d = (i == 0) || ($urandom_range(0, 399) == 0);
            en_d  = ($urandom_range(0, 9) != 0);
            #1;
            if (i > 0) begin
                cmp_dut("rnd_s", m_s, n_s, lt_s, int'(rst_s), int'(en_s), int'(x_s), int'(y_s),
                        int'(hs_s), int'(vs_s), int'(act_s), int'(pt_s), int'(ls_s), int'(fs_s), int'(rgb_s));
                cmp_dut("rnd_d", m_d, n_d, lt_d, int'(rst_d), int'(en_d), int'(x_d), int'(y_d),
                        int'(hs_d), int'(vs_d), int'(act_d), int'(pt_d), int'(ls_d), int'(fs_d), int'(rgb_d));
            end
            @(posedge clk);
            if (rst_s) begin n_s = 0; lt_s = 0; end
            else if (en_s) begin lt_s = ((n_s % m_s.div) == m_s.div - 1) ? 1 : 0; n_s++; end
            else lt_s = 0;
            if (rst_d) begin n_d = 0; lt_d = 0; end
            else if (en_d) begin lt_d = ((n_d % m_d.div) == m_d.div - 1) ? 1 : 0; n_d++; end
            else lt_d = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
